// File: rtl/trng_conditioner.sv
// trng_conditioner: von Neumann debiasing and byte packing of a synchronized
// raw entropy stream. Each finished byte is offered on a valid/ready port. A
// byte that finishes while the port is still full is dropped and counted.
// Optional feature macro: TRNG_HEALTH_EN builds the repetition-count health
// test and its sticky health_fail flag. Without the macro, health_fail is
// tied low.
module trng_conditioner #(
  parameter int unsigned RCT_CUTOFF = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       raw_bit,
  input  logic       raw_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       health_fail,
  output logic [7:0] drop_cnt
);

  // The cutoff must fit the 8-bit run counter and needs a run of at least 2.
  if (RCT_CUTOFF < 2 || RCT_CUTOFF > 255) begin : g_bad_cutoff
    $error("trng_conditioner: RCT_CUTOFF must lie in 2..255");
  end

  logic       accept;
  logic       have_first;
  logic       first_bit;
  logic       emit;
  logic       emit_bit;
  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       byte_done;
  logic [7:0] byte_next;
  logic       trip;
  logic       fail_now;

  assign accept    = raw_valid && en && !health_fail;
  // Pair 10 yields 1 and pair 01 yields 0, so the emitted bit is the first bit.
  assign emit      = accept && have_first && (first_bit != raw_bit);
  assign emit_bit  = first_bit;
  assign byte_done = emit && (cnt == 3'd7);
  assign byte_next = {shreg[6:0], emit_bit};
  // A tripping sample acts on the same edge as an already latched failure.
  assign fail_now  = health_fail || trip;

`ifdef TRNG_HEALTH_EN
  localparam logic [7:0] CUTOFF = 8'(RCT_CUTOFF);

  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       prev_bit;
  logic       fail_q;

  // Next run length: restart at 1 on a new value or on the first sample.
  always_comb begin
    run_next = run_cnt;
    if (run_cnt == 8'd0 || raw_bit != prev_bit) begin
      run_next = 8'd1;
    end else if (run_cnt != 8'hFF) begin
      run_next = run_cnt + 8'd1;
    end
  end

  assign trip        = accept && (run_next == CUTOFF);
  assign health_fail = fail_q;

  // Track raw run length and latch the sticky failure flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt  <= 8'd0;
      prev_bit <= 1'b0;
      fail_q   <= 1'b0;
    end else if (accept) begin
      run_cnt  <= run_next;
      prev_bit <= raw_bit;
      if (trip) begin
        fail_q <= 1'b1;
      end
    end
  end
`else
  assign trip        = 1'b0;
  assign health_fail = 1'b0;
`endif

  // Pair stage: hold the first sample of each pair until its partner arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (!en || fail_now) begin
      have_first <= 1'b0;
    end else if (accept) begin
      if (have_first) begin
        have_first <= 1'b0;
      end else begin
        have_first <= 1'b1;
        first_bit  <= raw_bit;
      end
    end
  end

  // Packer bit count. The 8th bit wraps it back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 3'd0;
    end else if (fail_now) begin
      cnt <= 3'd0;
    end else if (emit) begin
      cnt <= cnt + 3'd1;
    end
  end

  // Packer data: shift corrected bits in MSB-first. The count alone frames bytes.
  always_ff @(posedge clk) begin
    if (emit) begin
      shreg <= byte_next;
    end
  end

  // Output register: load, drop or consume each completed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      drop_cnt   <= 8'd0;
    end else if (fail_now) begin
      byte_valid <= 1'b0;
    end else if (byte_done) begin
      if (!byte_valid || byte_ready) begin
        byte_out   <= byte_next;
        byte_valid <= 1'b1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (byte_valid && byte_ready) begin
      byte_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trng_conditioner.sv
// Testbench for trng_conditioner. A queue of expected bytes is filled while
// stimulus is driven and drained as the DUT presents bytes.
module tb_trng_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       raw_bit = 1'b0;
  logic       raw_valid = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       health_fail;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp;

  trng_conditioner #(.RCT_CUTOFF(31)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .health_fail(health_fail), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One accepted sample per call. Returns 1 time unit after the sampling edge.
  task automatic send_sample(input logic b);
    raw_bit   = b;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  task automatic send_pair(input logic b);
    send_sample(b);
    send_sample(~b);
  endtask

  // Everything of a byte except the final sample. A 00 or 11 filler pair
  // precedes each bit when filler is set.
  task automatic send_byte_but_last(input logic [7:0] b, input bit filler);
    for (int i = 7; i >= 0; i--) begin
      if (filler) begin
        send_sample(b[i] ^ i[0]);
        send_sample(b[i] ^ i[0]);
      end
      if (i == 0) send_sample(b[0]);
      else        send_pair(b[i]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_byte_but_last(b, 1'b0);
    send_sample(~b[0]);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en         = 1'($urandom);
      raw_bit    = 1'($urandom);
      raw_valid  = 1'($urandom);
      byte_ready = 1'($urandom);
      @(negedge clk);
    end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out got %h want 00", byte_out); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL reset_health_fail got %b want 0", health_fail); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    en = 1'b1; raw_valid = 1'b0; byte_ready = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_debias;
    do_reset();
    exp_q.push_back(8'hA5);
    send_byte_but_last(8'hA5, 1'b1);
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL debias_early_valid got %b want 0", byte_valid); end
    send_sample(1'b0);
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL debias_valid got %b want 1", byte_valid); end
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp) begin errors++; $display("FAIL debias_byte got %h want %h", byte_out, exp); end
  endtask

  task automatic test_backpressure;
    // 0xA5 from test_debias is still held with byte_ready low.
    send_byte(8'h5A);
    checks++; if (byte_out !== 8'hA5) begin errors++; $display("FAIL bp_hold got %h want a5", byte_out); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL bp_drop1 got %0d want 1", drop_cnt); end
    for (int i = 0; i < 300; i++) send_byte(8'(i) ^ 8'h5A);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL bp_drop_sat got %0d want 255", drop_cnt); end
    checks++; if (byte_out !== 8'hA5 || byte_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_late got %h/%b want a5/1", byte_out, byte_valid); end
  endtask

  task automatic test_simultaneous;
    do_reset();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp || byte_valid !== 1'b1) begin errors++; $display("FAIL sim_first got %h/%b want %h/1", byte_out, byte_valid, exp); end
    exp_q.push_back(8'h3C);
    send_byte_but_last(8'h3C, 1'b0);
    byte_ready = 1'b1;
    send_sample(1'b1);
    byte_ready = 1'b0;
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp) begin errors++; $display("FAIL sim_byte got %h want %h", byte_out, exp); end
    checks++; if (byte_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %b want 1", byte_valid); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL sim_drop got %0d want 0", drop_cnt); end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    byte_ready = 1'b0;
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL consume_valid got %b want 0", byte_valid); end
    checks++; if (byte_out !== 8'h3C) begin errors++; $display("FAIL consume_hold got %h want 3c", byte_out); end
  endtask

  task automatic test_enable;
    do_reset();
    send_sample(1'b1);            // left pending as a first sample
    en = 1'b0;
    send_sample(1'b0);            // ignored; pending first sample discarded
    en = 1'b1;
    exp_q.push_back(8'h96);
    send_pair(1'b1); send_pair(1'b0); send_pair(1'b0); send_pair(1'b1);
    en = 1'b0;
    send_pair(1'b1); send_pair(1'b0); send_pair(1'b1);
    en = 1'b1;
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL en_partial_valid got %b want 0", byte_valid); end
    send_pair(1'b0); send_pair(1'b1); send_pair(1'b1); send_pair(1'b0);
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp || byte_valid !== 1'b1) begin errors++; $display("FAIL en_byte got %h/%b want %h/1", byte_out, byte_valid, exp); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int i = 0; i < 5; i++) send_pair(1'b1);
    send_sample(1'b1);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    exp_q.delete();
    checks++; if (byte_valid !== 1'b0 || drop_cnt !== 8'd0) begin errors++; $display("FAIL midrst_state got %b/%0d want 0/0", byte_valid, drop_cnt); end
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp || byte_valid !== 1'b1) begin errors++; $display("FAIL midrst_byte got %h/%b want %h/1", byte_out, byte_valid, exp); end
  endtask

`ifdef TRNG_HEALTH_EN
  task automatic test_health;
    do_reset();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp || byte_valid !== 1'b1) begin errors++; $display("FAIL hl_byte got %h/%b want %h/1", byte_out, byte_valid, exp); end
    for (int i = 0; i < 30; i++) send_sample(1'b1);
    send_sample(1'b0);
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL hl_run30 got %b want 0", health_fail); end
    for (int i = 0; i < 30; i++) send_sample(1'b1);
    checks++; if (health_fail !== 1'b0 || byte_valid !== 1'b1) begin errors++; $display("FAIL hl_pre_trip got %b/%b want 0/1", health_fail, byte_valid); end
    send_sample(1'b1);
    checks++; if (health_fail !== 1'b1) begin errors++; $display("FAIL hl_trip got %b want 1", health_fail); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL hl_valid_drop got %b want 0", byte_valid); end
    for (int i = 0; i < 3; i++) send_byte(8'h69);
    checks++; if (byte_valid !== 1'b0 || health_fail !== 1'b1 || drop_cnt !== 8'd0) begin errors++; $display("FAIL hl_locked got %b/%b/%0d want 0/1/0", byte_valid, health_fail, drop_cnt); end
  endtask
`else
  task automatic test_health;
    do_reset();
    for (int i = 0; i < 40; i++) send_sample(1'b1);
    checks++; if (health_fail !== 1'b0) begin errors++; $display("FAIL hl_disabled got %b want 0", health_fail); end
    exp_q.push_back(8'h69);
    send_byte(8'h69);
    exp = exp_q.pop_front();
    checks++; if (byte_out !== exp || byte_valid !== 1'b1) begin errors++; $display("FAIL hl_disabled_byte got %h/%b want %h/1", byte_out, byte_valid, exp); end
  endtask
`endif

  initial begin
    test_reset();
    test_debias();
    test_backpressure();
    test_simultaneous();
    test_enable();
    test_mid_reset();
    test_health();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
